// File: rtl/mem_lsu.sv
// Load/store unit with an optional read-modify-write increment.
// One transaction in flight: accept in idle, access the data memory, optionally
// write back an incremented value, then hold the response until consumed.
// Optional feature macro: LSU_INC_EN enables the INC op (op 10); without it op 10
// is treated as reserved and the modify stage is not built.
module mem_lsu #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_w,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  localparam logic [1:0] OpLd = 2'b00;
  localparam logic [1:0] OpSt = 2'b01;
`ifdef LSU_INC_EN
  localparam logic [1:0] OpInc = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StModify = 2'd2,
    StResp   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd3
  } state_e;
`endif

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
  logic [DATA_SIZE-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   mem_w_raw;

  // State and transaction registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, register updates and memory/handshake outputs.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_w_raw = 1'b0;
    mem_wdata = wdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        state_d = StResp;
        case (op_q)
          OpLd: rdata_d = mem_rdata;
          OpSt: begin
            mem_w_raw = 1'b1;
            mem_wdata = wdata_q;
            rdata_d   = '0;
          end
`ifdef LSU_INC_EN
          OpInc: begin
            // Old value is returned to the core and also feeds the incrementer.
            rdata_d = mem_rdata;
            state_d = StModify;
          end
`endif
          default: begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        endcase
      end
`ifdef LSU_INC_EN
      StModify: begin
        // Wraps silently at the top of the range.
        mem_w_raw = 1'b1;
        mem_wdata = rdata_q + {{(DATA_SIZE-1){1'b0}}, 1'b1};
        state_d   = StResp;
      end
`endif
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A reset cycle must never write memory, even mid-transaction.
  assign mem_w     = mem_w_raw & rstn;
  assign mem_addr  = addr_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, meaning data word width.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 5, meaning data memory address width.
REQ-003 The block SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-004 The block SHALL have port rstn, input, 1, meaning reset; rstn is synchronous, active-low, and the clock is clk.
REQ-005 The block SHALL have port req_valid, input, 1, meaning core request present.
REQ-006 The block SHALL have port req_ready, output, 1, meaning request accepted this cycle when req_valid is also high.
REQ-007 The block SHALL have port req_op, input, 2, meaning 00 = LD, 01 = ST, 10 = INC, 11 = reserved.
REQ-008 The block SHALL have port req_addr, input, ADDR_SIZE, meaning target word address.
REQ-009 The block SHALL have port req_wdata, input, DATA_SIZE, meaning store data.
REQ-010 The block SHALL have port rsp_valid, output, 1, meaning response present.
REQ-011 The block SHALL have port rsp_ready, input, 1, meaning core consumes the response.
REQ-012 The block SHALL have port rsp_rdata, output, DATA_SIZE, meaning load data or old value.
REQ-013 The block SHALL have port rsp_err, output, 1, meaning unsupported op.
REQ-014 The block SHALL have ports mem_w (output, 1), mem_addr (output, ADDR_SIZE) and mem_wdata (output, DATA_SIZE), meaning data memory write enable, address and write data.
REQ-015 The block SHALL have port mem_rdata, input, DATA_SIZE, meaning data memory combinational read data for mem_addr.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, MODIFY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, on req_valid=1 the block SHALL latch op, addr and wdata into registers and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-018 mem_addr SHALL always equal the latched address register.
REQ-019 In ACCESS for LD, the block SHALL capture mem_rdata into the rdata register and go to RESP.
REQ-020 In ACCESS for ST, the block SHALL drive mem_w=1 and mem_wdata=latched wdata, load the rdata register with 0, and go to RESP.
REQ-021 In ACCESS for INC, the block SHALL capture mem_rdata (old value) into the rdata register and go to MODIFY.
REQ-022 In MODIFY, the block SHALL drive mem_w=1 and mem_wdata=(rdata register + 1) mod 2^DATA_SIZE, then go to RESP; 0xFF SHALL wrap to 0x00 with no flag.
REQ-023 For a reserved op (or INC when disabled), ACCESS SHALL not assert mem_w, SHALL load rdata 0, set the error register and go to RESP.
REQ-024 In RESP, rsp_valid SHALL be 1, with rsp_rdata and rsp_err held stable until rsp_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-025 mem_w SHALL be 0 in IDLE and RESP, and in every cycle where rstn=0.
REQ-026 Latency from the accept edge to rsp_valid SHALL be 2 cycles for LD, ST and error, and 3 cycles for INC.
REQ-027 No new request SHALL be accepted until the response handshake completes, giving a maximum of one outstanding transaction.
REQ-028 A request presented while req_ready=0 SHALL be ignored and not latched.

Reset
REQ-029 On rstn=0 at a clk edge, the FSM SHALL go to IDLE, and the address, wdata, rdata, op and error registers SHALL be cleared to 0.
REQ-030 After reset, the outputs SHALL be req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_w=0 and mem_addr=0.
REQ-031 A reset in ACCESS or MODIFY SHALL abort the transaction with no write issued in the reset cycle and no response produced.

Configuration
REQ-032 Macro LSU_INC_EN defined SHALL enable the INC op as specified.
REQ-033 Without LSU_INC_EN, op 10 SHALL be treated as reserved (REQ-023), and the MODIFY state and incrementer SHALL be absent.

Verification
REQ-034 Reset, then LD addr 5 (memory reset contents word i = i) -> rsp_valid two cycles after accept, rsp_rdata=0x05, rsp_err=0.
REQ-035 ST addr 3 wdata 0xA5, then LD addr 3 -> exactly one mem_w pulse, with mem_addr=3 and mem_wdata=0xA5; the LD returns 0xA5.
REQ-036 ST addr 7 0xFF, INC addr 7, LD addr 7 (LSU_INC_EN defined) -> the INC returns 0xFF and the MODIFY write is 0x00; the LD returns 0x00.
REQ-037 Op 11 addr 2 -> rsp_err=1, rsp_rdata=0, no mem_w; the same test with op 10 and LSU_INC_EN undefined gives the same result.
REQ-038 Hold rsp_ready=0 for 5 cycles with req_valid=1 continuously -> rsp_valid and data are stable, req_ready=0 and the new request is not latched; it is accepted the cycle after the handshake.
REQ-039 Assert rstn=0 during the INC ACCESS cycle -> no mem_w pulse, rsp_valid=0 and the FSM is in IDLE the next cycle.
